// File: rtl/issue_pair_pkg.sv
// issue_pkg: micro-op type, bubble constant and register helpers shared by the issue_pair block.
package issue_pkg;
    localparam int UOP_REG_W = 5;
    localparam int UOP_DATA_W = 32;
    localparam logic [UOP_REG_W-1:0] LINK_REG = 5'd31;
    typedef struct packed {
        logic                  JumpLink;
        logic                  RegWrite;
        logic                  MemtoReg;
        logic                  MemWrite;
        logic [2:0]            ALUControl;
        logic                  ALUSrc;
        logic                  RegDst;
        logic                  BitShift;
        logic [UOP_DATA_W-1:0] rd1;
        logic [UOP_DATA_W-1:0] rd2;
        logic [UOP_REG_W-1:0]  rs;
        logic [UOP_REG_W-1:0]  rt;
        logic [UOP_REG_W-1:0]  rd;
        logic [UOP_DATA_W-1:0] Imm;
        logic [UOP_REG_W-1:0]  BitNum;
        logic [UOP_DATA_W-1:0] PCPlus4;
    } uop_t;
    localparam uop_t BUBBLE_UOP = '0;
    function automatic logic [UOP_REG_W-1:0] dest_reg(uop_t u);
        return u.JumpLink ? LINK_REG : (u.RegDst ? u.rd : u.rt);
    endfunction
    function automatic logic writes_reg(uop_t u);
        return u.RegWrite && dest_reg(u) != '0;
    endfunction
    function automatic logic is_mem(uop_t u);
        return u.MemtoReg || u.MemWrite;
    endfunction
endpackage

// File: rtl/issue_pair_if.sv
// issue_pair_if: decode-side pair handshake, downstream control and execute-slot outputs.
interface issue_pair_if;
    import issue_pkg::*;
    logic in_valid_a;
    logic in_valid_b;
    uop_t in_a;
    uop_t in_b;
    logic in_ready;
    logic stall_i;
    logic flush_i;
    logic out_valid_a;
    logic out_valid_b;
    uop_t out_a;
    uop_t out_b;
    modport master (
        output in_valid_a, in_valid_b, in_a, in_b, stall_i, flush_i,
        input  in_ready, out_valid_a, out_valid_b, out_a, out_b
    );
    modport slave (
        input  in_valid_a, in_valid_b, in_a, in_b, stall_i, flush_i,
        output in_ready, out_valid_a, out_valid_b, out_a, out_b
    );
endinterface

// File: rtl/issue_hazard.sv
// issue_hazard: combinational pair-split and load-use detection; ISSUE_PAIR_DUAL_EN enables true dual issue.
module issue_hazard
    import issue_pkg::*;
#(
    parameter int REG_W = UOP_REG_W
) (
    input  uop_t in_a_i,
    input  uop_t in_b_i,
    input  uop_t hold_i,
    input  uop_t slot_a_i,
    input  uop_t slot_b_i,
    input  logic slot_va_i,
    input  logic slot_vb_i,
    output logic split_o,
    output logic lu_a_o,
    output logic lu_b_o,
    output logic lu_hold_o
);
    logic [REG_W-1:0] dst_sa, dst_sb;
    logic ld_sa, ld_sb;
    logic unused_bits;
    function automatic logic reads(uop_t u, logic [REG_W-1:0] r);
        return u.rs == r || u.rt == r;
    endfunction
    assign dst_sa = REG_W'(dest_reg(slot_a_i));
    assign dst_sb = REG_W'(dest_reg(slot_b_i));
    assign ld_sa = slot_va_i && slot_a_i.MemtoReg && writes_reg(slot_a_i);
    assign ld_sb = slot_vb_i && slot_b_i.MemtoReg && writes_reg(slot_b_i);
    assign lu_a_o = (ld_sa && reads(in_a_i, dst_sa)) || (ld_sb && reads(in_a_i, dst_sb));
    assign lu_b_o = (ld_sa && reads(in_b_i, dst_sa)) || (ld_sb && reads(in_b_i, dst_sb));
    assign lu_hold_o = (ld_sa && reads(hold_i, dst_sa)) || (ld_sb && reads(hold_i, dst_sb));
`ifdef ISSUE_PAIR_DUAL_EN
    logic [REG_W-1:0] dst_in_a;
    assign dst_in_a = REG_W'(dest_reg(in_a_i));
    assign split_o = (writes_reg(in_a_i) && reads(in_b_i, dst_in_a))
                   || (is_mem(in_a_i) && is_mem(in_b_i)) || in_a_i.JumpLink;
`else
    // Single-issue build: B is always deferred behind A.
    assign split_o = 1'b1;
`endif
    assign unused_bits = ^{in_a_i, in_b_i, hold_i, slot_a_i, slot_b_i};
endmodule

// File: rtl/issue_pair.sv
// issue_pair: dual-issue stage registering decode pairs into execute slots A/B with split, load-use, stall and flush.
// Dual issue is enabled by defining ISSUE_PAIR_DUAL_EN; otherwise the block issues one instruction per cycle.
module issue_pair
    import issue_pkg::*;
#(
    parameter int REG_W  = UOP_REG_W,
    parameter int DATA_W = UOP_DATA_W
) (
    input logic         clk,
    input logic         reset_n,
    issue_pair_if.slave bus
);
    localparam bit CFG_OK = REG_W == UOP_REG_W && DATA_W == UOP_DATA_W;
    uop_t out_a_q, out_a_d, out_b_q, out_b_d, hold_q, hold_d;
    logic va_q, va_d, vb_q, vb_d, hold_valid_q, hold_valid_d;
    logic split, lu_a, lu_b, lu_hold, accept;
    issue_hazard #(.REG_W(REG_W)) u_hazard (
        .in_a_i    (bus.in_a),
        .in_b_i    (bus.in_b),
        .hold_i    (hold_q),
        .slot_a_i  (out_a_q),
        .slot_b_i  (out_b_q),
        .slot_va_i (va_q),
        .slot_vb_i (vb_q),
        .split_o   (split),
        .lu_a_o    (lu_a),
        .lu_b_o    (lu_b),
        .lu_hold_o (lu_hold)
    );
    // A load-use hit on B blocks the whole pair so it is never reordered.
    assign accept = CFG_OK && reset_n && !bus.flush_i && !bus.stall_i && !hold_valid_q
                  && bus.in_valid_a && !lu_a && !(bus.in_valid_b && lu_b);
    always_comb begin
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        va_d = va_q;
        vb_d = vb_q;
        hold_d = hold_q;
        hold_valid_d = hold_valid_q;
        if (bus.flush_i) begin
            out_a_d = BUBBLE_UOP;
            out_b_d = BUBBLE_UOP;
            va_d = 1'b0;
            vb_d = 1'b0;
            hold_valid_d = 1'b0;
        end else if (!bus.stall_i) begin
            out_a_d = BUBBLE_UOP;
            out_b_d = BUBBLE_UOP;
            va_d = 1'b0;
            vb_d = 1'b0;
            if (hold_valid_q) begin
                if (!lu_hold) begin
                    out_a_d = hold_q;
                    va_d = 1'b1;
                    hold_valid_d = 1'b0;
                end
            end else if (accept) begin
                out_a_d = bus.in_a;
                va_d = 1'b1;
                if (bus.in_valid_b && split) begin
                    hold_d = bus.in_b;
                    hold_valid_d = 1'b1;
                end else if (bus.in_valid_b) begin
                    out_b_d = bus.in_b;
                    vb_d = 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_a_q <= BUBBLE_UOP;
            out_b_q <= BUBBLE_UOP;
            hold_q <= BUBBLE_UOP;
            va_q <= 1'b0;
            vb_q <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            hold_q <= hold_d;
            va_q <= va_d;
            vb_q <= vb_d;
            hold_valid_q <= hold_valid_d;
        end
    end
    assign bus.in_ready = accept;
    assign bus.out_valid_a = va_q;
    assign bus.out_valid_b = vb_q;
    assign bus.out_a = out_a_q;
    assign bus.out_b = out_b_q;
endmodule
